// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the one-hot ring round-robin arbiter.
// Helpers work on a fixed RR_MAX_N-wide vector; callers zero-extend and truncate.
package ring_arb_pkg;

    localparam int unsigned RR_MAX_N = 32;
    localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Binary index of the set bit; ORing indices keeps it a pure mux-free reduction.
    function automatic logic [RR_IDX_W-1:0] onehot2bin(input logic [RR_MAX_N-1:0] vec);
        logic [RR_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < RR_MAX_N; i++) begin
            if (vec[i]) idx = idx | RR_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [RR_MAX_N-1:0] rotl1(input logic [RR_MAX_N-1:0] vec,
                                                  input int unsigned           n);
        logic [RR_MAX_N-1:0] res;
        res = '0;
        for (int unsigned i = 1; i < RR_MAX_N; i++) begin
            if (i < n) res[i] = vec[i-1];
        end
        res[0] = vec[n-1];
        return res;
    endfunction

endpackage

// File: rtl/onehot_ring_ptr.sv
// N-bit one-hot ring pointer: load or single-step rotate, reset to bit 0,
// and self-recovery to bit 0 if the register ever holds a non-one-hot value.
module onehot_ring_ptr
    import ring_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] ptr_o
);

    localparam logic [N-1:0] PTR_RESET = N'(1);

    logic [N-1:0] ptr_q;
    logic [N-1:0] ptr_d;
    logic         ptr_onehot;

    assign ptr_onehot = (ptr_q != '0) && ((ptr_q & (ptr_q - N'(1))) == '0);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (!ptr_onehot) begin
            ptr_d = PTR_RESET;
        end else if (advance_i) begin
            ptr_d = N'(rotl1(RR_MAX_N'(ptr_q), N));
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= PTR_RESET;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with one-hot ring priority; the owner keeps the grant until release.
// Define RR_HOLD_TIMEOUT_EN to revoke an owner after MAX_HOLD consecutive grant cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int unsigned IDW = $clog2(N);

    if (N < 2 || N > RR_MAX_N || MAX_HOLD < 2) begin : g_param_check
        $error("ring_rr_arbiter: parameter out of range");
    end

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q;
    logic           gnt_valid_q;
    logic [N-1:0]   ptr;
    logic [N-1:0]   rot_gnt;
    logic           owner_req;
    logic           hand_off;
    logic           hold_expired;
    logic           ptr_advance;
    logic           ptr_load;

    // First requester at or above the position of start, wrapping; last write wins.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] start);
        logic [N-1:0] res;
        int unsigned  base;
        int unsigned  idx;
        res  = '0;
        base = 32'(onehot2bin(RR_MAX_N'(start)));
        for (int unsigned k = 0; k < N; k++) begin
            idx = (base + (N - 1 - k)) % N;
            if (r[idx]) begin
                res      = '0;
                res[idx] = 1'b1;
            end
        end
        return res;
    endfunction

    assign owner_req = |(req & gnt_q);
    assign rot_gnt   = N'(rotl1(RR_MAX_N'(gnt_q), N));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        hand_off = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    gnt_d   = pick(req, ptr);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A revoked owner still requesting is scanned last, so it only wins when alone.
                if (!owner_req || hold_expired) begin
                    hand_off = 1'b1;
                    gnt_d    = pick(req, rot_gnt);
                    state_d  = (|gnt_d) ? GRANT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign ptr_advance = hand_off && (gnt_q == ptr);
    assign ptr_load    = hand_off && (gnt_q != ptr);

    onehot_ring_ptr #(.N(N)) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .advance_i  (ptr_advance),
        .load_i     (ptr_load),
        .load_val_i (rot_gnt),
        .ptr_o      (ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= IDW'(onehot2bin(RR_MAX_N'(gnt_d)));
            gnt_valid_q <= |gnt_d;
        end
    end

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int unsigned HCW = $clog2(MAX_HOLD);

    logic [HCW-1:0] hold_q, hold_d;
    logic           timeout_q;

    // hold_q is 0 in the owner's first cycle, so MAX_HOLD-1 marks its last allowed cycle.
    assign hold_expired = (state_q == GRANT) && (hold_q == HCW'(MAX_HOLD - 1));

    always_comb begin
        hold_d = hold_q + HCW'(1);
        if (state_q != GRANT || hand_off) hold_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= hold_expired && owner_req;
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an owner/pointer reference model.
module tb_ring_rr_arbiter;

    localparam int unsigned N = 4;
`ifdef RR_HOLD_TIMEOUT_EN
    localparam int unsigned MAX_HOLD = 4;
    localparam bit          TMO_EN   = 1'b1;
`else
    localparam int unsigned MAX_HOLD = 8;
    localparam bit          TMO_EN   = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0]         gnt;
    logic                 gnt_valid;
    logic [$clog2(N)-1:0] gnt_id;
    logic                 timeout;

    int n_cmp = 0;
    int n_err = 0;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), priority start index, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;
    bit m_valid = 1'b0;

    function automatic int pick_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_tmo   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                m_owner = pick_from(req, m_ptr);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick_from(req, m_ptr);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else if (TMO_EN && m_held == int'(MAX_HOLD)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick_from(req, m_ptr);
                m_held  = 1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [31:0] exp_gnt;
            exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
            check("model_gnt", 32'(gnt), exp_gnt);
            check("model_gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("model_timeout", 32'(timeout), 32'(m_tmo));
        end
    end

    // Drive req for one clock edge; returns at the following falling edge.
    task automatic cyc(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r;
        rst = 1'b1;
        req = '0;
        @(negedge clk);

        // Reset held two cycles with all requests up.
        cyc(4'b1111);
        cyc(4'b1111);
        check("t1_gnt", 32'(gnt), 32'h0);
        check("t1_valid", 32'(gnt_valid), 32'h0);
        check("t1_id", 32'(gnt_id), 32'h0);
        rst = 1'b0;

        // Single request from idle, then release to idle.
        cyc(4'b0100);
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_id", 32'(gnt_id), 32'h2);
        cyc(4'b0000);
        check("t2_idle", 32'(gnt), 32'h0);

        // Full rotation from a freshly reset pointer.
        rst = 1'b1;
        cyc(4'b0000);
        rst = 1'b0;
        cyc(4'b1111);
        for (int k = 0; k < 4; k++) begin
            check("t3_first", 32'(gnt), 32'd1 << k);
            cyc(4'b1111);
            check("t3_hold", 32'(gnt), 32'd1 << k);
            r = 4'b1111;
            r[k] = 1'b0;
            cyc(r);
        end
        check("t3_wrap", 32'(gnt), 32'h1);

        // Direct handoff 0001 -> 0010 with no idle cycle.
        cyc(4'b0001);
        check("t4_owner", 32'(gnt), 32'h1);
        cyc(4'b1010);
        check("t4_handoff", 32'(gnt), 32'h2);
        check("t4_valid", 32'(gnt_valid), 32'h1);

        // Reset in the middle of a grant restores the pointer to bit 0.
        cyc(4'b0100);
        cyc(4'b0100);
        check("t5_held", 32'(gnt), 32'h4);
        rst = 1'b1;
        cyc(4'b0100);
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        cyc(4'b1100);
        check("t5_after_rst", 32'(gnt), 32'h4);
        check("t5_id", 32'(gnt_id), 32'h2);
        cyc(4'b0000);

`ifdef RR_HOLD_TIMEOUT_EN
        // Hold timeout: alternate between two requesters, then a lone requester is regranted.
        rst = 1'b1;
        cyc(4'b0000);
        rst = 1'b0;
        cyc(4'b0011);
        check("t6_g0", 32'(gnt), 32'h1);
        check("t6_t0", 32'(timeout), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0011);
            check("t6_g0_hold", 32'(gnt), 32'h1);
        end
        cyc(4'b0011);
        check("t6_g1", 32'(gnt), 32'h2);
        check("t6_pulse1", 32'(timeout), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0011);
            check("t6_g1_hold", 32'(gnt), 32'h2);
            check("t6_nopulse", 32'(timeout), 32'h0);
        end
        cyc(4'b0011);
        check("t6_g0_again", 32'(gnt), 32'h1);
        check("t6_pulse2", 32'(timeout), 32'h1);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                cyc(4'b0001);
                check("t6_solo_hold", 32'(gnt), 32'h1);
                check("t6_solo_nopulse", 32'(timeout), 32'h0);
            end
            cyc(4'b0001);
            check("t6_regrant", 32'(gnt), 32'h1);
            check("t6_solo_pulse", 32'(timeout), 32'h1);
        end
        cyc(4'b0000);
`endif

        // Randomized traffic: each request line toggles with probability 1/4, rare resets.
        r = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < int'(N); b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            rst = ($urandom_range(199) == 0);
            cyc(r);
        end
        rst = 1'b0;
        cyc(4'b0000);
        cyc(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
